// File: rtl/data_ram_if.sv
// CPU data-port bus for data_ram. err_o is only present when
// DATA_RAM_ERR_EN is defined.
interface data_ram_if;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ready_o;
`ifdef DATA_RAM_ERR_EN
    logic        err_o;

    modport master (output ce_i, we_i, addr_i, sel_i, data_i,
                    input  data_o, ready_o, err_o);
    modport slave  (input  ce_i, we_i, addr_i, sel_i, data_i,
                    output data_o, ready_o, err_o);
`else
    modport master (output ce_i, we_i, addr_i, sel_i, data_i,
                    input  data_o, ready_o);
    modport slave  (input  ce_i, we_i, addr_i, sel_i, data_i,
                    output data_o, ready_o);
`endif
endinterface

// File: rtl/data_ram.sv
// data_ram: single-port 32-bit word RAM behind a CPU data-port handshake.
// A request is latched in IDLE, waits WAIT_CYCLES in BUSY, and completes
// with a one-cycle ready_o pulse in RESP. Byte enables are big-endian
// (sel_i[3] -> data[31:24]).
// Optional feature macro: DATA_RAM_ERR_EN -- adds err_o and flags any
// address with bits above the array range set; such accesses do not write
// and return zero data.
module data_ram #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 10
) (
    input  logic        clk,
    input  logic        rst,
    data_ram_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_cnt, w_cnt_nxt;

    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_sel;
    logic [31:0]         r_wdata;
    logic                r_oob;

    logic [31:0]         r_mem [DEPTH];
    logic                r_ready;
    logic [31:0]         r_rdata;

    logic                w_accept;
    logic                w_commit;
    logic                w_oob_in;
    logic                w_req_we;
    logic [ADDR_W-1:0]   w_req_addr;
    logic [3:0]          w_req_sel;
    logic [31:0]         w_req_wdata;
    logic                w_req_oob;
    logic                w_unused;

`ifdef DATA_RAM_ERR_EN
    logic                r_err;
    assign w_oob_in = |bus.addr_i[31:ADDR_W+2];
    assign w_unused = ^bus.addr_i[1:0];
    assign bus.err_o = r_err;
`else
    assign w_oob_in = 1'b0;
    assign w_unused = ^{bus.addr_i[1:0], bus.addr_i[31:ADDR_W+2]};
`endif

    assign w_accept = (r_state == IDLE) && bus.ce_i;
    // Access happens on the edge that enters RESP; reset on that edge wins.
    assign w_commit = rst && (w_state_nxt == RESP) && (r_state != RESP);

    // With zero wait states the commit edge is the accept edge, so the
    // request has to come straight from the bus rather than the latches.
    assign w_req_we    = (r_state == IDLE) ? bus.we_i                   : r_we;
    assign w_req_addr  = (r_state == IDLE) ? bus.addr_i[ADDR_W+1:2]     : r_addr;
    assign w_req_sel   = (r_state == IDLE) ? bus.sel_i                  : r_sel;
    assign w_req_wdata = (r_state == IDLE) ? bus.data_i                 : r_wdata;
    assign w_req_oob   = (r_state == IDLE) ? w_oob_in                   : r_oob;

    // State and wait counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; ce_i only matters in IDLE, so requests cannot abort.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.ce_i) begin
                    w_cnt_nxt   = 4'(WAIT_CYCLES);
                    w_state_nxt = (WAIT_CYCLES > 0) ? BUSY : RESP;
                end
            end
            BUSY: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) w_state_nxt = RESP;
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request latch, captured when a request is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_sel   <= 4'd0;
            r_wdata <= 32'd0;
            r_oob   <= 1'b0;
        end else if (w_accept) begin
            r_we    <= bus.we_i;
            r_addr  <= bus.addr_i[ADDR_W+1:2];
            r_sel   <= bus.sel_i;
            r_wdata <= bus.data_i;
            r_oob   <= w_oob_in;
        end
    end

    // Byte-masked write into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_commit && w_req_we && !w_req_oob) begin
            for (int b = 0; b < 4; b++) begin
                if (w_req_sel[b]) r_mem[w_req_addr][8*b +: 8] <= w_req_wdata[8*b +: 8];
            end
        end
    end

    // Registered response: ready pulse, read data (held otherwise), error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ready <= w_commit;
            if (w_commit) begin
                if (w_req_oob)      r_rdata <= 32'd0;
                else if (!w_req_we) r_rdata <= r_mem[w_req_addr];
            end
        end
    end

`ifdef DATA_RAM_ERR_EN
    // Error flag accompanies the ready pulse only.
    always_ff @(posedge clk) begin
        if (!rst) r_err <= 1'b0;
        else      r_err <= w_commit && w_req_oob;
    end
`endif

    assign bus.ready_o = r_ready;
    assign bus.data_o  = r_rdata;

endmodule
